renkon_pool: RTL and testbench

RENKON_POOL -- requirements
Module: renkon_pool

---
 rtl/renkon_pkg.sv | 13 +
 rtl/renkon_linebuf.sv | 24 ++
 rtl/renkon_pool.sv | 105 ++++++++++
 tb/tb_renkon_pool.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/renkon_pkg.sv
// Shared renkon constants: default datapath/dimension widths and pooling FSM encoding.
package renkon_pkg;

   localparam int RENKON_DWIDTH = 16;
   localparam int RENKON_LWIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } pool_state_t;

endpackage

// File: rtl/renkon_linebuf.sv
// Single-port synchronous line buffer holding the pooled pair maxima of one even row.
module renkon_linebuf
   import renkon_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH,
   parameter int AWIDTH = RENKON_LWIDTH - 1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [AWIDTH-1:0]        addr,
   input  logic signed [DWIDTH-1:0] wdata,
   output logic signed [DWIDTH-1:0] rdata
);

   logic signed [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

   // rdata only moves on a read, so it stays valid until the next read is issued.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/renkon_pool.sv
// 2x2 stride-2 signed max pooling over a raster-order pixel stream.
module renkon_pool
   import renkon_pkg::*;
#(
   parameter int DWIDTH = RENKON_DWIDTH,
   parameter int LWIDTH = RENKON_LWIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init,
   input  logic [LWIDTH-1:0]        img_w,
   input  logic [LWIDTH-1:0]        img_h,
   input  logic                     in_en,
   input  logic signed [DWIDTH-1:0] pixel_in,
   output logic                     out_en,
   output logic signed [DWIDTH-1:0] pixel_out,
   output logic                     done
);

   localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

   pool_state_t state, state_nxt;
   logic [LWIDTH-1:0] col, row, width, height;
   logic signed [DWIDTH-1:0] pair_q, lb_rdata, pair_max, quad_max;
   logic accept, col_last, row_last, lb_we, lb_re;

   function automatic logic signed [DWIDTH-1:0] smax(input logic signed [DWIDTH-1:0] a,
                                                     input logic signed [DWIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // init wins over a same-cycle pixel.
   assign accept   = (state == ST_RUN) && in_en && !init;
   assign col_last = (col == width - ONE);
   assign row_last = (row == height - ONE);
   assign lb_we    = accept && !row[0] && col[0];
   assign lb_re    = accept && row[0] && !col[0];
   assign pair_max = smax(pair_q, pixel_in);
   assign quad_max = smax(pair_max, lb_rdata);

   always_comb begin
      state_nxt = state;
      if (init) begin
         state_nxt = ST_RUN;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_RUN:  if (accept && col_last && row_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         width     <= '0;
         height    <= '0;
         pair_q    <= '0;
         pixel_out <= '0;
         out_en    <= 1'b0;
         done      <= 1'b0;
      end else begin
         out_en <= accept && row[0] && col[0];
         // done trails the last pooled output, or the last pixel when that pixel pools nothing.
         done   <= (accept && col_last && row_last && !(row[0] && col[0]))
                || (state == ST_DONE && out_en);
         if (init) begin
            col    <= '0;
            row    <= '0;
            width  <= img_w;
            height <= img_h;
         end else if (accept) begin
            if (col_last) begin
               col <= '0;
               row <= row + ONE;
            end else begin
               col <= col + ONE;
            end
            if (!col[0]) pair_q <= pixel_in;
            if (row[0] && col[0]) pixel_out <= quad_max;
         end
      end
   end

   renkon_linebuf #(
      .DWIDTH (DWIDTH),
      .AWIDTH (LWIDTH - 1)
   ) u_linebuf (
      .clk   (clk),
      .we    (lb_we),
      .re    (lb_re),
      .addr  (col[LWIDTH-1:1]),
      .wdata (pair_max),
      .rdata (lb_rdata)
   );

endmodule

// File: tb/tb_renkon_pool.sv
// Randomized and directed checks of renkon_pool against a whole-map 2x2 max-pool model.
module tb_renkon_pool;

   localparam int DW = 16;
   localparam int LW = 10;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 init = 1'b0;
   logic [LW-1:0]        img_w = '0;
   logic [LW-1:0]        img_h = '0;
   logic                 in_en = 1'b0;
   logic signed [DW-1:0] pixel_in = '0;
   logic                 out_en;
   logic signed [DW-1:0] pixel_out;
   logic                 done;

   renkon_pool #(.DWIDTH(DW), .LWIDTH(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .init      (init),
      .img_w     (img_w),
      .img_h     (img_h),
      .in_en     (in_en),
      .pixel_in  (pixel_in),
      .out_en    (out_en),
      .pixel_out (pixel_out),
      .done      (done)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int misses  = 0;
   logic signed [DW-1:0] map_q[$];
   logic signed [DW-1:0] exp_q[$];
   logic signed [DW-1:0] got_q[$];
   int done_cnt = 0;
   int done_cyc = -1;
   int hold_err = 0;
   logic signed [DW-1:0] last_out = '0;

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         misses++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (out_en) got_q.push_back(pixel_out);
      else if (pixel_out !== last_out) hold_err++;
      last_out = pixel_out;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // reference model: pool the whole stored map at once
   function automatic logic signed [DW-1:0] vmax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic build_expected(input int w, input int h);
      logic signed [DW-1:0] m;
      exp_q.delete();
      for (int r = 0; r < h / 2; r++) begin
         for (int c = 0; c < w / 2; c++) begin
            m = vmax(vmax(map_q[2*r*w + 2*c], map_q[2*r*w + 2*c + 1]),
                     vmax(map_q[(2*r+1)*w + 2*c], map_q[(2*r+1)*w + 2*c + 1]));
            exp_q.push_back(m);
         end
      end
   endtask

   // driver tasks; each starts and ends 1 time unit after a rising edge
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         in_en    = 1'($urandom_range(0, 1));
         pixel_in = DW'($urandom);
         @(posedge clk); #1;
      end
      in_en = 1'b0;
   endtask

   task automatic start_map(input int w, input int h);
      init     = 1'b1;
      img_w    = LW'(w);
      img_h    = LW'(h);
      in_en    = 1'($urandom_range(0, 1));
      pixel_in = DW'($urandom);
      got_q.delete();
      done_cnt = 0;
      hold_err = 0;
      @(posedge clk); #1;
      init  = 1'b0;
      in_en = 1'b0;
      img_w = LW'($urandom);
      img_h = LW'($urandom);
   endtask

   task automatic feed(input int n, input int gmin, input int gmax, output int last_cyc);
      last_cyc = 0;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(gmin, gmax)) begin
            in_en    = 1'b0;
            pixel_in = DW'($urandom);
            @(posedge clk); #1;
         end
         in_en    = 1'b1;
         pixel_in = map_q[i];
         last_cyc = cyc;
         @(posedge clk); #1;
      end
      in_en = 1'b0;
   endtask

   task automatic run_map(input int w, input int h, input int gmin, input int gmax);
      int lc;
      int lat;
      build_expected(w, h);
      start_map(w, h);
      feed(w * h, gmin, gmax, lc);
      idle_cycles(6);
      lat = ((w % 2 == 0) && (h % 2 == 0)) ? 2 : 1;
      check($sformatf("n_out_%0dx%0d", w, h), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("pix%0d_%0dx%0d", i, w, h), got_q[i], exp_q[i]);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_cyc, lc + lat);
      check("out_hold", hold_err, 0);
   endtask

   task automatic load(input int v[], input int n);
      map_q.delete();
      for (int i = 0; i < n; i++) map_q.push_back(DW'(v[i]));
   endtask

   initial begin
      int a8[] = '{1, 5, 2, 3, 4, 0, 7, 6};
      int s4[] = '{-8, -3, -5, -9};
      int u4[] = '{1, 2, 3, 4};
      int lc;
      int w;
      int h;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_en", int'(out_en), 0);
      check("rst_done", int'(done), 0);
      check("rst_pixel_out", int'(pixel_out), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycles(3);
      check("idle_no_out", got_q.size(), 0);

      // back-to-back and gapped 4x2 maps: 5 then 7
      load(a8, 8);
      run_map(4, 2, 0, 0);
      run_map(4, 2, 3, 3);

      // signed compare
      load(s4, 4);
      run_map(2, 2, 0, 1);

      // odd width and height, ascending 0..14
      map_q.delete();
      for (int i = 0; i < 15; i++) map_q.push_back(DW'(i));
      run_map(5, 3, 0, 1);

      // reset mid-map, then a fresh 2x2
      load(a8, 8);
      start_map(4, 2);
      feed(3, 0, 0, lc);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      last_out = '0;
      check("abort_pixel_out", int'(pixel_out), 0);
      idle_cycles(4);
      check("abort_no_out", got_q.size(), 0);
      check("abort_no_done", done_cnt, 0);
      load(u4, 4);
      run_map(2, 2, 0, 0);

      // init mid-row of a running map
      load(a8, 8);
      start_map(4, 2);
      feed(2, 0, 1, lc);
      load(u4, 4);
      run_map(2, 2, 0, 2);

      // randomized maps, mixing wide-range and tie-heavy narrow-range data
      for (int t = 0; t < 25; t++) begin
         w = $urandom_range(2, 9);
         h = $urandom_range(2, 7);
         map_q.delete();
         for (int i = 0; i < w * h; i++) begin
            if (t % 2 == 0) map_q.push_back(DW'($urandom));
            else            map_q.push_back(DW'(int'($urandom_range(0, 6)) - 3));
         end
         run_map(w, h, 0, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
